// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and the width helper for the sync_fifo_flags FIFO.
// Optional error flags are enabled by defining SYNC_FIFO_ERR_FLAGS_EN.
package sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 8;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

   // Smallest r with 2**r >= n; returns 0 for n <= 1.
   function automatic int clog2_ceil(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage with one write port and a registered read port.
// Only the read-data register is reset; the array contents are not.
module sync_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags, read-valid strobe and flush.
// Define SYNC_FIFO_ERR_FLAGS_EN to get sticky overflow/underflow flags.
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clr,
   input  logic                              w_en,
   input  logic [DATA_WIDTH-1:0]             data_in,
   input  logic                              r_en,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              rd_valid,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic [clog2_ceil(DEPTH+1)-1:0]    count,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int CW = clog2_ceil(DEPTH + 1);
   localparam int PW = clog2_ceil(DEPTH);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [PW-1:0] w_ptr_reg, w_ptr_next;
   logic [PW-1:0] r_ptr_reg, r_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          rd_valid_reg;
   logic          wr_acc, rd_acc;
   fifo_status_t  status;

   // Status is decoded from the registered count only, never from the requests.
   always_comb begin
      status.full         = (count_reg == DEPTH_C);
      status.empty        = (count_reg == '0);
      status.almost_full  = (count_reg >= AF_C);
      status.almost_empty = (count_reg <= AE_C);
   end

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign count        = count_reg;
   assign rd_valid     = rd_valid_reg;

   assign wr_acc = w_en & ~status.full  & ~clr;
   assign rd_acc = r_en & ~status.empty & ~clr;

   always_comb begin
      w_ptr_next = w_ptr_reg;
      r_ptr_next = r_ptr_reg;
      count_next = count_reg;
      if (clr) begin
         w_ptr_next = '0;
         r_ptr_next = '0;
         count_next = '0;
      end else begin
         if (wr_acc) begin
            w_ptr_next = (w_ptr_reg == LAST_PTR) ? '0 : w_ptr_reg + PW'(1);
         end
         if (rd_acc) begin
            r_ptr_next = (r_ptr_reg == LAST_PTR) ? '0 : r_ptr_reg + PW'(1);
         end
         if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
         end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr_reg    <= '0;
         r_ptr_reg    <= '0;
         count_reg    <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         w_ptr_reg    <= w_ptr_next;
         r_ptr_reg    <= r_ptr_next;
         count_reg    <= count_next;
         rd_valid_reg <= rd_acc;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (w_ptr_reg),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (r_ptr_reg),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_reg, underflow_reg;

   // Rejected requests are flagged on the raw request; a flush clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (clr) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (w_en && status.full) begin
            overflow_reg <= 1'b1;
         end
         if (r_en && status.empty) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: three instances (DEPTH 8/5/4) share one stimulus set.
// Error-flag expectations follow SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_flags;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       w_en;
   logic       r_en;
   logic [7:0] data_in;

   logic [7:0] d8_dout, d5_dout, d4_dout;
   logic       d8_rv, d5_rv, d4_rv;
   logic       d8_full, d5_full, d4_full;
   logic       d8_empty, d5_empty, d4_empty;
   logic       d8_af, d5_af, d4_af;
   logic       d8_ae, d5_ae, d4_ae;
   logic [3:0] d8_cnt;
   logic [2:0] d5_cnt, d4_cnt;
   logic       d8_ovf, d5_ovf, d4_ovf;
   logic       d8_udf, d5_udf, d4_udf;

   int n_cmp;
   int n_err;

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_d8 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(d8_dout), .rd_valid(d8_rv), .full(d8_full), .empty(d8_empty),
      .almost_full(d8_af), .almost_empty(d8_ae), .count(d8_cnt),
      .overflow(d8_ovf), .underflow(d8_udf)
   );

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5)) u_d5 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(d5_dout), .rd_valid(d5_rv), .full(d5_full), .empty(d5_empty),
      .almost_full(d5_af), .almost_empty(d5_ae), .count(d5_cnt),
      .overflow(d5_ovf), .underflow(d5_udf)
   );

   sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(d4_dout), .rd_valid(d4_rv), .full(d4_full), .empty(d4_empty),
      .almost_full(d4_af), .almost_empty(d4_ae), .count(d4_cnt),
      .overflow(d4_ovf), .underflow(d4_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      w_en    = 1'b0;
      r_en    = 1'b0;
      clr     = 1'b0;
      data_in = 8'h00;
      rst_n   = 1'b0;
      #3;
      rst_n   = 1'b1;
      tick();
   endtask

   initial begin
      int rd;
      n_cmp = 0;
      n_err = 0;

      // Reset then idle
      reset_dut();
      tick();
      check_val("rst_count", 32'(d8_cnt), 0);
      check_val("rst_empty", 32'(d8_empty), 1);
      check_val("rst_ae", 32'(d8_ae), 1);
      check_val("rst_full", 32'(d8_full), 0);
      check_val("rst_af", 32'(d8_af), 0);
      check_val("rst_dout", 32'(d8_dout), 0);
      check_val("rst_rv", 32'(d8_rv), 0);
      check_val("rst_ovf", 32'(d8_ovf), 0);
      check_val("rst_udf", 32'(d8_udf), 0);

      // DEPTH=8 fill with AF=6 / AE=2 thresholds
      for (int i = 1; i <= 8; i++) begin
         w_en = 1'b1;
         data_in = 8'(i);
         tick();
         check_val($sformatf("fill%0d_count", i), 32'(d8_cnt), 32'(i));
         check_val($sformatf("fill%0d_ae", i), 32'(d8_ae), (i <= 2) ? 1 : 0);
         check_val($sformatf("fill%0d_af", i), 32'(d8_af), (i >= 6) ? 1 : 0);
         check_val($sformatf("fill%0d_full", i), 32'(d8_full), (i == 8) ? 1 : 0);
         check_val($sformatf("fill%0d_empty", i), 32'(d8_empty), 0);
      end
      data_in = 8'hFF;
      tick();
      check_val("ovf_write_count", 32'(d8_cnt), 8);
      check_val("ovf_write_full", 32'(d8_full), 1);
      check_val("ovf_set", 32'(d8_ovf), 32'(ERR));
      w_en = 1'b0;

      for (int i = 1; i <= 8; i++) begin
         r_en = 1'b1;
         tick();
         check_val($sformatf("drain%0d_dout", i), 32'(d8_dout), 32'(i));
         check_val($sformatf("drain%0d_rv", i), 32'(d8_rv), 1);
         check_val($sformatf("drain%0d_count", i), 32'(d8_cnt), 32'(8 - i));
         check_val($sformatf("drain%0d_ae", i), 32'(d8_ae), (8 - i <= 2) ? 1 : 0);
         check_val($sformatf("drain%0d_af", i), 32'(d8_af), (8 - i >= 6) ? 1 : 0);
      end
      check_val("drained_empty", 32'(d8_empty), 1);
      r_en = 1'b0;
      tick();
      check_val("idle_rv", 32'(d8_rv), 0);
      check_val("idle_dout_hold", 32'(d8_dout), 8);
      check_val("ovf_sticky", 32'(d8_ovf), 32'(ERR));

      r_en = 1'b1;
      tick();
      check_val("udf_read_rv", 32'(d8_rv), 0);
      check_val("udf_read_count", 32'(d8_cnt), 0);
      check_val("udf_set", 32'(d8_udf), 32'(ERR));
      r_en = 1'b0;

      // Flush: clr beats simultaneous w_en/r_en and leaves data_out alone
      for (int i = 0; i < 3; i++) begin
         w_en = 1'b1;
         data_in = 8'hA1 + 8'(i);
         tick();
      end
      w_en = 1'b0;
      r_en = 1'b1;
      tick();
      check_val("pre_clr_dout", 32'(d8_dout), 32'h A1);
      check_val("pre_clr_count", 32'(d8_cnt), 2);
      clr = 1'b1;
      w_en = 1'b1;
      data_in = 8'hB0;
      tick();
      check_val("clr_count", 32'(d8_cnt), 0);
      check_val("clr_empty", 32'(d8_empty), 1);
      check_val("clr_rv", 32'(d8_rv), 0);
      check_val("clr_dout_hold", 32'(d8_dout), 32'h A1);
      check_val("clr_ovf", 32'(d8_ovf), 0);
      check_val("clr_udf", 32'(d8_udf), 0);
      clr = 1'b0;
      data_in = 8'hC3;
      r_en = 1'b0;
      tick();
      w_en = 1'b0;
      r_en = 1'b1;
      tick();
      check_val("post_clr_dout", 32'(d8_dout), 32'h C3);
      r_en = 1'b0;

      // DEPTH=5: stream across pointer wrap, 20 accepted writes total
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         w_en = 1'b1;
         data_in = 8'h10 + 8'(k);
         tick();
      end
      check_val("d5_prefill_count", 32'(d5_cnt), 4);
      rd = 0;
      for (int k = 4; k < 19; k++) begin
         w_en = 1'b1;
         r_en = 1'b1;
         data_in = 8'h10 + 8'(k);
         tick();
         check_val($sformatf("d5_stream%0d_dout", k), 32'(d5_dout), 32'h10 + 32'(rd));
         check_val($sformatf("d5_stream%0d_count", k), 32'(d5_cnt), 4);
         rd++;
      end
      r_en = 1'b0;
      data_in = 8'h23;
      tick();
      check_val("d5_full_count", 32'(d5_cnt), 5);
      check_val("d5_full", 32'(d5_full), 1);
      data_in = 8'h77;
      tick();
      check_val("d5_reject_count", 32'(d5_cnt), 5);
      w_en = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         r_en = 1'b1;
         tick();
         check_val($sformatf("d5_drain%0d_dout", j), 32'(d5_dout), 32'h10 + 32'(rd));
         check_val($sformatf("d5_drain%0d_rv", j), 32'(d5_rv), 1);
         check_val($sformatf("d5_drain%0d_count", j), 32'(d5_cnt), 32'(5 - j));
         rd++;
      end
      check_val("d5_empty", 32'(d5_empty), 1);
      r_en = 1'b0;

      // DEPTH=4: simultaneous requests while full and while empty
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         w_en = 1'b1;
         data_in = 8'h40 + 8'(k);
         tick();
      end
      check_val("d4_full", 32'(d4_full), 1);
      r_en = 1'b1;
      data_in = 8'hAA;
      tick();
      check_val("d4_both_full_dout", 32'(d4_dout), 32'h40);
      check_val("d4_both_full_count", 32'(d4_cnt), 3);
      check_val("d4_both_full_rv", 32'(d4_rv), 1);
      w_en = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         tick();
         check_val($sformatf("d4_drain%0d_dout", j), 32'(d4_dout), 32'h40 + 32'(j));
      end
      check_val("d4_drained_count", 32'(d4_cnt), 0);
      w_en = 1'b1;
      data_in = 8'h55;
      tick();
      check_val("d4_both_empty_count", 32'(d4_cnt), 1);
      check_val("d4_both_empty_rv", 32'(d4_rv), 0);
      check_val("d4_both_empty_dout", 32'(d4_dout), 32'h43);
      w_en = 1'b0;
      tick();
      check_val("d4_after_dout", 32'(d4_dout), 32'h55);
      r_en = 1'b0;

      // Asynchronous reset mid-burst, no clock edge needed
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         w_en = 1'b1;
         data_in = 8'h31 + 8'(k);
         tick();
      end
      r_en = 1'b1;
      data_in = 8'h34;
      tick();
      check_val("burst_dout", 32'(d8_dout), 32'h31);
      check_val("burst_count", 32'(d8_cnt), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_count", 32'(d8_cnt), 0);
      check_val("arst_empty", 32'(d8_empty), 1);
      check_val("arst_dout", 32'(d8_dout), 0);
      check_val("arst_rv", 32'(d8_rv), 0);
      tick();
      check_val("arst_held_count", 32'(d8_cnt), 0);
      rst_n = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      tick();
      check_val("arst_release_empty", 32'(d8_empty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
